// File: rtl/fpu_pkg.sv
// Shared types and helpers for the shared-fadd arbiter: float field layout,
// arbiter FSM states and tag width.
package fpu_pkg;

  typedef struct packed {
    logic [7:0] sign_w;
    logic [7:0] exp_w;
    logic [7:0] man_w;
  } fp_fmt_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  function automatic fp_fmt_t fp_fmt(input int n);
    fp_fmt_t f;
    f.sign_w = 8'd1;
    if (n == 64) begin
      f.exp_w = 8'd11;
      f.man_w = 8'd52;
    end else begin
      f.exp_w = 8'd8;
      f.man_w = 8'd23;
    end
    return f;
  endfunction

  // Requester tag width; never zero so a 1-bit tag survives NREQ=1 elaboration.
  function automatic int tag_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fadd_arbiter_if.sv
// Requester, fadd and control signals of the shared-fadd arbiter.
// slave is the arbiter's view, master is the clients/adder/control side.
interface fadd_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][N-1:0]  req_a;
  logic [NREQ-1:0][N-1:0]  req_b;
  logic                    fa_vld;
  logic [N-1:0]            fa_a;
  logic [N-1:0]            fa_b;
  logic [N-1:0]            fa_res;
  logic [NREQ-1:0]         rsp_valid;
  logic [N-1:0]            rsp_data;
  logic                    flush;
  logic                    flush_done;
  logic                    busy;

  modport slave (
    input  req_valid, req_a, req_b, fa_res, flush,
    output req_ready, fa_vld, fa_a, fa_b, rsp_valid, rsp_data, flush_done, busy
  );

  modport master (
    output req_valid, req_a, req_b, fa_res, flush,
    input  req_ready, fa_vld, fa_a, fa_b, rsp_valid, rsp_data, flush_done, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant searching upward from ptr, plus the pointer after a grant.
// Purely combinational; zero latency, no backpressure of its own.
module rr_arbiter import fpu_pkg::*; #(
  parameter  int NREQ = 4,
  localparam int TW   = tag_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [TW-1:0]   grant_idx,
  output logic [TW-1:0]   next_ptr
);

  logic          found;
  logic [TW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    next_ptr  = ptr;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = TW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        next_ptr   = TW'((int'(idx) + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined fadd among NREQ requesters; result returns LAT+1 edges after the handshake.
// Grants are withheld during flush/drain; responses cannot be backpressured. FADD_ARB_STATS_EN adds stat_issued.
module fadd_arbiter import fpu_pkg::*; #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fadd_arbiter_if.slave     bus
`ifdef FADD_ARB_STATS_EN
  ,
  output logic [31:0]       stat_issued
`endif
);

  localparam int TW = tag_w(NREQ);
  localparam int CW = $clog2(LAT + 2);

  arb_state_t state, state_nx;
  logic                   grant_en;
  logic [TW-1:0]          ptr, ptr_nx, grant_idx;
  logic [NREQ-1:0]        grant, ready;
  logic                   hs;
  logic [CW-1:0]          cnt;
  logic                   fa_vld_q;
  logic [TW-1:0]          fa_tag_q;
  logic [N-1:0]           fa_a_q, fa_b_q;
  logic [LAT-1:0]         pipe_vld;
  logic [LAT-1:0][TW-1:0] pipe_tag;
  logic                   rsp_evt;
  logic [NREQ-1:0]        rsp_valid_q;
  logic [N-1:0]           rsp_data_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .next_ptr  (ptr_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    unique case (state)
      RUN: begin
        grant_en = ~bus.flush;
        if (bus.flush) state_nx = DRAIN;
      end
      // flush level is deliberately ignored here: a started drain always completes.
      DRAIN: if (cnt == '0) state_nx = DONE;
      DONE:  if (!bus.flush) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Gating with rst_n keeps req_ready low while reset is held, not just after the first edge.
  assign ready   = (grant_en && rst_n) ? grant : '0;
  assign hs      = |ready;
  assign rsp_evt = pipe_vld[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      fa_vld_q <= 1'b0;
      fa_tag_q <= '0;
      fa_a_q   <= '0;
      fa_b_q   <= '0;
    end else begin
      fa_vld_q <= hs;
      if (hs) begin
        ptr      <= ptr_nx;
        fa_tag_q <= grant_idx;
        fa_a_q   <= bus.req_a[grant_idx];
        fa_b_q   <= bus.req_b[grant_idx];
      end
      if (hs && !rsp_evt)      cnt <= cnt + CW'(1);
      else if (!hs && rsp_evt) cnt <= cnt - CW'(1);
    end
  end

  // Tag stage s holds the issue that the adder's stage s is working on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld    <= '0;
      pipe_tag    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      pipe_vld[0] <= fa_vld_q;
      pipe_tag[0] <= fa_tag_q;
      for (int s = 1; s < LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end
      rsp_valid_q <= rsp_evt ? (NREQ'(1) << pipe_tag[LAT-1]) : '0;
      if (rsp_evt) rsp_data_q <= bus.fa_res;
    end
  end

`ifdef FADD_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   stat_issued <= '0;
    else if (state == DRAIN && state_nx == DONE)  stat_issued <= '0;
    else if (hs && stat_issued != 32'hFFFF_FFFF)  stat_issued <= stat_issued + 32'd1;
  end
`endif

  assign bus.req_ready  = ready;
  assign bus.fa_vld     = fa_vld_q;
  assign bus.fa_a       = fa_a_q;
  assign bus.fa_b       = fa_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.flush_done = (state == DONE) && bus.flush;
  assign bus.busy       = (cnt != '0);

endmodule
